execute_muldiv: RTL

Iterative multiply/divide unit for the execute stage, generalised to `WIDTH`-bit operands. It resolves its own A/B operand forwarding from the XM and MW pipeline registers and runs a radix-2 shift-add multiply or restoring divide over `WIDTH` cycles. While busy it holds the pipeline with `stall`, then presents the result for exactly one cycle. It sits beside the main ALU in EX; its `result` is muxed onto the EX output when `result_valid` is high.

---
 rtl/execute_muldiv_if.sv | 35 +++
 rtl/execute_muldiv.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/execute_muldiv_if.sv
// execute_muldiv_if: EX-stage bundle for the iterative multiply/divide unit.
//   master : EX control side, drives the instruction, operands, forwarding
//            selects and flush, and receives stall/result/result_valid/div_zero.
//   slave  : the execute_muldiv unit itself.
// WIDTH sets the operand/result width and must match the unit's WIDTH.
interface execute_muldiv_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic [1:0]       op;
  logic             op_signed;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic [1:0]       fwdA_sel;
  logic [1:0]       fwdB_sel;
  logic [WIDTH-1:0] XM_value;
  logic [WIDTH-1:0] MW_value;
  logic             flush;
  logic             stall;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             div_zero;

  modport master (
    output in_valid, op, op_signed, srcA, srcB, fwdA_sel, fwdB_sel,
           XM_value, MW_value, flush,
    input  stall, result, result_valid, div_zero
  );

  modport slave (
    input  in_valid, op, op_signed, srcA, srcB, fwdA_sel, fwdB_sel,
           XM_value, MW_value, flush,
    output stall, result, result_valid, div_zero
  );
endinterface

// File: rtl/execute_muldiv.sv
// execute_muldiv: iterative radix-2 multiply / restoring divide for EX.
//   clk, rst : rising-edge clock, asynchronous active-high reset.
//   bus      : execute_muldiv_if.slave
//     in_valid/op/op_signed      instruction (00 MUL, 01 MULH, 10 DIV, 11 REM)
//     srcA/srcB, fwdA_sel/fwdB_sel, XM_value/MW_value  operand forwarding
//     flush                      discard in-flight or arriving operation
//     stall                      hold IF/ID/EX while accepting or busy
//     result/result_valid        one-cycle registered result strobe
//     div_zero                   qualifies result_valid: divisor was 0
// Optional feature: define MULDIV_SIGNED_EN to honour op_signed (magnitude
// conversion at accept, sign fix-up at completion). Without it every
// operation is unsigned.
module execute_muldiv #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic             clk,
  input logic             rst,
  execute_muldiv_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  // MUL/MULH: {product_hi, multiplier/product_lo}; DIV/REM: {rem, quot}
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // multiplicand for MUL/MULH, divisor for DIV/REM
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic [WIDTH-1:0]   opa, opb;
  logic [WIDTH-1:0]   maga, magb;
  logic               accept;

  // Operand forwarding
  always_comb begin
    case (bus.fwdA_sel)
      2'b01:   opa = bus.XM_value;
      2'b10:   opa = bus.MW_value;
      default: opa = bus.srcA;
    endcase
    case (bus.fwdB_sel)
      2'b01:   opb = bus.XM_value;
      2'b10:   opb = bus.MW_value;
      default: opb = bus.srcB;
    endcase
  end

`ifdef MULDIV_SIGNED_EN
  logic neg_q, neg_d;
  logic sgn_op;

  assign sgn_op = bus.op_signed;

  always_comb begin
    maga = (sgn_op && opa[WIDTH-1]) ? -opa : opa;
    magb = (sgn_op && opb[WIDTH-1]) ? -opb : opb;
  end
`else
  logic unused_op_signed;

  assign unused_op_signed = bus.op_signed;
  assign maga = opa;
  assign magb = opb;
`endif

  assign accept = (state_q == IDLE) && bus.in_valid && !bus.flush;

  // One iteration step of the selected algorithm
  logic [WIDTH:0]     msum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] acc_step;

  always_comb begin
    msum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, opnd_q};
    if (!op_q[1]) begin
      // carry out of the add becomes the new MSB after the right shift
      acc_step = {msum, acc_q[WIDTH-1:1]};
    end else if (!trial[WIDTH]) begin
      acc_step = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  // Final result selection from the last iteration's value
  logic [2*WIDTH-1:0] prod_fin;
  logic [WIDTH-1:0]   quot_fin, rem_fin, final_res;

  always_comb begin
    prod_fin = acc_step;
    quot_fin = acc_step[WIDTH-1:0];
    rem_fin  = acc_step[2*WIDTH-1:WIDTH];
`ifdef MULDIV_SIGNED_EN
    if (neg_q) begin
      prod_fin = -acc_step;
      quot_fin = -acc_step[WIDTH-1:0];
      rem_fin  = -acc_step[2*WIDTH-1:WIDTH];
    end
`endif
    case (op_q)
      OP_MUL:  final_res = prod_fin[WIDTH-1:0];
      OP_MULH: final_res = prod_fin[2*WIDTH-1:WIDTH];
      // a zero divisor already leaves rem = |dividend|; only the quotient
      // needs forcing so the sign fix-up cannot disturb it
      OP_DIV:  final_res = dz_q ? '1 : quot_fin;
      default: final_res = rem_fin;
    endcase
  end

  // Next-state / datapath control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    dz_d     = dz_q;
    result_d = '0;
`ifdef MULDIV_SIGNED_EN
    neg_d    = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(WIDTH);
          op_d    = bus.op;
          dz_d    = bus.op[1] && (opb == '0);
          if (bus.op[1]) begin
            acc_d  = {{WIDTH{1'b0}}, maga};
            opnd_d = magb;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, magb};
            opnd_d = maga;
          end
`ifdef MULDIV_SIGNED_EN
          // remainder follows the dividend, everything else follows A ^ B
          neg_d = sgn_op && ((bus.op == 2'b11) ? opa[WIDTH-1]
                                               : (opa[WIDTH-1] ^ opb[WIDTH-1]));
`endif
        end
      end
      BUSY: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d  = DONE;
            result_d = final_res;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      dz_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      dz_q     <= dz_d;
      result_q <= result_d;
    end
  end

`ifdef MULDIV_SIGNED_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= neg_d;
    end
  end
`endif

  assign bus.stall        = accept || (state_q == BUSY);
  assign bus.result       = result_q;
  assign bus.result_valid = (state_q == DONE) && !bus.flush;
  assign bus.div_zero     = (state_q == DONE) && !bus.flush && dz_q;

endmodule
